// File: rtl/pio_regs_pkg.sv
// Shared register-map definitions for the debounced PIO input block.
package pio_regs_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_MASK = 2'd1,
        ADDR_EDGE = 2'd2,
        ADDR_RAW  = 2'd3
    } reg_addr_e;

    localparam int unsigned AVS_DATA_W = 32;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer followed by a stable-time debounce counter.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        INIT_VAL        = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic raw_o,
    output logic debounced_o,
    output logic debounced_next_o
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             raw_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= INIT_VAL;
            raw_q  <= INIT_VAL;
            deb_q  <= INIT_VAL;
            cnt_q  <= '0;
        end else begin
            meta_q <= pin_i;
            raw_q  <= meta_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (raw_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = raw_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign raw_o            = raw_q;
    assign debounced_o      = deb_q;
    assign debounced_next_o = deb_d;

endmodule

// File: rtl/pio_inputs_avs.sv
// Debounced slide-switch inputs behind an Avalon-MM slave with edge capture and level IRQ.
module pio_inputs_avs
    import pio_regs_pkg::*;
#(
    parameter int unsigned      WIDTH           = 10,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INIT            = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      pins_in,
    input  logic [1:0]            avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [AVS_DATA_W-1:0] avs_writedata,
    output logic [AVS_DATA_W-1:0] avs_readdata,
    output logic                  irq
);

    logic [WIDTH-1:0]      raw;
    logic [WIDTH-1:0]      deb;
    logic [WIDTH-1:0]      deb_next;
    logic [WIDTH-1:0]      edge_set;
    logic [WIDTH-1:0]      w1c;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [WIDTH-1:0]      edge_q, edge_d;
    logic [AVS_DATA_W-1:0] rdata_q, rdata_d;
    logic                  irq_q, irq_d;
    logic                  unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT_VAL        (INIT[i])
        ) u_debounce (
            .clk              (clk),
            .reset_n          (reset_n),
            .pin_i            (pins_in[i]),
            .raw_o            (raw[i]),
            .debounced_o      (deb[i]),
            .debounced_next_o (deb_next[i])
        );
    end

    // Edge capture sets on the same edge the debounced value changes.
    assign edge_set     = deb ^ deb_next;
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        mask_d  = mask_q;
        rdata_d = rdata_q;
        w1c     = '0;
        if (avs_write) begin
            case (reg_addr_e'(avs_address))
                ADDR_MASK: mask_d = avs_writedata[WIDTH-1:0];
                ADDR_EDGE: w1c    = avs_writedata[WIDTH-1:0];
                default:   ;
            endcase
        end
        // A new edge outranks a simultaneous clear of the same bit.
        edge_d = (edge_q & ~w1c) | edge_set;
        if (avs_read) begin
            unique case (reg_addr_e'(avs_address))
                ADDR_DATA: rdata_d = AVS_DATA_W'(deb);
                ADDR_MASK: rdata_d = AVS_DATA_W'(mask_q);
                ADDR_EDGE: rdata_d = AVS_DATA_W'(edge_q);
                ADDR_RAW:  rdata_d = AVS_DATA_W'(raw);
            endcase
        end
        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            edge_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_pio_inputs_avs.sv
// Randomized bench for pio_inputs_avs: history-window reference model plus read-data scoreboard.
module tb_pio_inputs_avs;

    localparam int               WIDTH = 10;
    localparam int               DC    = 4;
    localparam logic [WIDTH-1:0] INIT  = '0;

    logic             clk           = 1'b0;
    logic             reset_n       = 1'b0;
    logic [WIDTH-1:0] pins_in       = '0;
    logic [1:0]       avs_address   = '0;
    logic             avs_read      = 1'b0;
    logic             avs_write     = 1'b0;
    logic [31:0]      avs_writedata = '0;
    logic [31:0]      avs_readdata;
    logic             irq;

    always #5 clk = ~clk;

    pio_inputs_avs #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DC),
        .INIT            (INIT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pins_in       (pins_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit is accepted once the last DC synchronized samples all disagree with it.
    logic [WIDTH-1:0] m_s1   = INIT;
    logic [WIDTH-1:0] m_raw  = INIT;
    logic [WIDTH-1:0] m_deb  = INIT;
    logic [WIDTH-1:0] m_mask = '0;
    logic [WIDTH-1:0] m_edge = '0;
    logic             m_irq  = 1'b0;
    logic [WIDTH-1:0] hist[$];
    logic [31:0]      sb[$];
    logic [31:0]      held   = '0;

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_edge);
            default: return 32'(m_raw);
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_s1   = INIT;
            m_raw  = INIT;
            m_deb  = INIT;
            m_mask = '0;
            m_edge = '0;
            m_irq  = 1'b0;
            hist.delete();
            sb.delete();
            held   = '0;
        end else begin
            logic [WIDTH-1:0] flip;
            logic [WIDTH-1:0] w1c;
            hist.push_back(m_raw);
            if (hist.size() > DC) void'(hist.pop_front());
            flip = '0;
            if (hist.size() == DC) begin
                flip = '1;
                foreach (hist[k]) flip &= hist[k] ^ m_deb;
            end
            if (avs_read) sb.push_back(reg_value(avs_address));
            w1c    = (avs_write && avs_address == 2'd2) ? avs_writedata[WIDTH-1:0] : '0;
            m_irq  = |(m_edge & m_mask);
            m_edge = (m_edge & ~w1c) | flip;
            if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[WIDTH-1:0];
            m_deb  = m_deb ^ flip;
            m_raw  = m_s1;
            m_s1   = pins_in;
        end
    end

    // Monitor: each read response is popped one cycle after issue; otherwise readdata must hold.
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (sb.size() > 0) begin
                held = sb.pop_front();
                check("readdata", avs_readdata, held);
            end else begin
                check("readdata_hold", avs_readdata, held);
            end
            check("irq", {31'b0, irq}, {31'b0, m_irq});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = a;
        avs_writedata = d;
        tick();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d);
    endtask

    task automatic do_reset();
        avs_read  = 1'b0;
        avs_write = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_readdata", avs_readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("por_readdata", avs_readdata, 32'h0);
        check("por_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Reset values of DATA, IRQ_MASK, EDGE_CAP.
        rd(2'd0);
        rd(2'd1);
        rd(2'd2);

        // Bit 0 rises and is polled every cycle to pin down the acceptance latency.
        pins_in = 10'h001;
        repeat (8) rd(2'd0);
        rd(2'd2);
        tick();

        // Unmask the captured edge, then clear it.
        wr(2'd1, 32'h001);
        repeat (2) tick();
        wr(2'd2, 32'h001);
        repeat (2) tick();
        rd(2'd2);

        // Three-cycle glitch on bit 3 must show in RAW only.
        pins_in = 10'h009;
        repeat (3) rd(2'd3);
        pins_in = 10'h001;
        repeat (6) rd(2'd3);
        rd(2'd0);
        rd(2'd2);

        // Bit 0 falls on the very edge that a W1C of bit 0 is sampled.
        pins_in = 10'h000;
        repeat (5) tick();
        wr(2'd2, 32'h001);
        rd(2'd2);
        rd(2'd0);

        // Reset two cycles into a bit-5 debounce, then the full latency again.
        wr(2'd2, 32'h3FF);
        pins_in = 10'h020;
        repeat (4) tick();
        do_reset();
        repeat (8) rd(2'd0);
        rd(2'd1);
        rd(2'd2);

        // Randomized traffic with glitches, overlapping read/write, and occasional reset.
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 5) == 0)
                pins_in = pins_in ^ WIDTH'(32'd1 << $urandom_range(0, WIDTH - 1));
            if ($urandom_range(0, 40) == 0)
                pins_in = WIDTH'($urandom);
            avs_read      = 1'($urandom_range(0, 1));
            avs_write     = ($urandom_range(0, 3) == 0);
            avs_address   = 2'($urandom_range(0, 3));
            avs_writedata = $urandom;
            if (it % 500 == 499) do_reset();
            else tick();
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
